// File: rtl/sr_register_bank_if.sv
// Bus bundle for sr_register_bank: enable, set/reset requests and channel state.
// conflict_cnt exists only when SR_CONFLICT_CNT_EN is defined.
interface sr_register_bank_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
);
  logic             en;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qn;
  logic [WIDTH-1:0] changed;
  logic             conflict;
`ifdef SR_CONFLICT_CNT_EN
  logic [CNT_W-1:0] conflict_cnt;

  modport master (
    output en, s, r,
    input  q, qn, changed, conflict, conflict_cnt
  );

  modport slave (
    input  en, s, r,
    output q, qn, changed, conflict, conflict_cnt
  );
`else
  modport master (
    output en, s, r,
    input  q, qn, changed, conflict
  );

  modport slave (
    input  en, s, r,
    output q, qn, changed, conflict
  );
`endif
endinterface

// File: rtl/sr_register_bank.sv
// Bank of WIDTH independent registered SR channels with selectable S=R=1 resolution.
// Define SR_CONFLICT_CNT_EN to add the saturating conflict_cnt counter.
module sr_register_bank #(
  parameter int unsigned      WIDTH = 8,
  parameter int unsigned      MODE  = 0,
  parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b0}},
  parameter int unsigned      CNT_W = 8
) (
  input logic               clk,
  input logic               rst,
  sr_register_bank_if.slave bus
);

  // Out-of-range MODE values fall back to hold.
  localparam int unsigned MODE_EFF = (MODE > 3) ? 0 : MODE;

  generate
    if (WIDTH < 1 || WIDTH > 64 || CNT_W < 1) begin : g_bad_param
      $error("sr_register_bank: WIDTH must be 1..64 and CNT_W at least 1");
    end
  endgenerate

  function automatic logic resolve(input logic q, input logic s, input logic r);
    logic n;
    n = q;
    case ({s, r})
      2'b10:   n = 1'b1;
      2'b01:   n = 1'b0;
      2'b11: begin
        case (MODE_EFF)
          1:       n = 1'b1;
          2:       n = 1'b0;
          3:       n = ~q;
          default: n = q;
        endcase
      end
      default: n = q;
    endcase
    return n;
  endfunction

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] changed_q;
  logic             conflict_q;
  logic             any_conflict;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_chan
      assign q_d[gi] = resolve(q_q[gi], bus.s[gi], bus.r[gi]);
    end
  endgenerate

  assign any_conflict = |(bus.s & bus.r);

  // Pulses are cleared on disabled edges so they never outlive one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q        <= INIT;
      changed_q  <= '0;
      conflict_q <= 1'b0;
    end else if (bus.en) begin
      q_q        <= q_d;
      changed_q  <= q_d ^ q_q;
      conflict_q <= any_conflict;
    end else begin
      changed_q  <= '0;
      conflict_q <= 1'b0;
    end
  end

  assign bus.q        = q_q;
  assign bus.qn       = ~q_q;
  assign bus.changed  = changed_q;
  assign bus.conflict = conflict_q;

`ifdef SR_CONFLICT_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // One step per conflicting enabled edge, sticking at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.en && any_conflict && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.conflict_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_sr_register_bank.sv
// Self-checking bench: four banks (MODE 0..3) share stimulus; a reference model
// pushes expected state into a scoreboard queue, popped after each clock edge.
`timescale 1ns/1ps
module tb_sr_register_bank;
  localparam int W  = 8;
  localparam int CW = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [W-1:0] s;
  logic [W-1:0] r;

  always #5 clk = ~clk;

  logic [3:0][W-1:0] q_mon;
  logic [3:0][W-1:0] qn_mon;
  logic [3:0][W-1:0] ch_mon;
  logic [3:0]        cf_mon;
`ifdef SR_CONFLICT_CNT_EN
  logic [3:0][CW-1:0] cnt_mon;
`endif

  for (genvar gi = 0; gi < 4; gi++) begin : g_mode
    sr_register_bank_if #(.WIDTH(W), .CNT_W(CW)) bus ();
    assign bus.en = en;
    assign bus.s  = s;
    assign bus.r  = r;
    sr_register_bank #(.WIDTH(W), .MODE(gi), .INIT({W{1'b0}}), .CNT_W(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
    assign q_mon[gi]  = bus.q;
    assign qn_mon[gi] = bus.qn;
    assign ch_mon[gi] = bus.changed;
    assign cf_mon[gi] = bus.conflict;
`ifdef SR_CONFLICT_CNT_EN
    assign cnt_mon[gi] = bus.conflict_cnt;
`endif
  end

  typedef struct packed {
    logic [3:0][W-1:0] q;
    logic [3:0][W-1:0] ch;
    logic              cf;
    logic [CW-1:0]     cnt;
  } exp_t;

  exp_t              exp_q[$];
  logic [3:0][W-1:0] m_q;
  logic [CW-1:0]     m_cnt;
  int                n_checks = 0;
  int                n_errors = 0;
  int                n_txn    = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, want);
    end
  endtask

  function automatic logic ref_bit(input int mode, input logic q, input logic sb, input logic rb);
    if (sb && !rb) return 1'b1;
    if (!sb && rb) return 1'b0;
    if (!sb && !rb) return q;
    if (mode == 1) return 1'b1;
    if (mode == 2) return 1'b0;
    if (mode == 3) return ~q;
    return q;
  endfunction

  task automatic step(input logic rst_v, input logic en_v, input logic [W-1:0] s_v, input logic [W-1:0] r_v);
    exp_t pred;
    exp_t want;
    logic nb;
    rst = rst_v; en = en_v; s = s_v; r = r_v;
    pred.ch = '0;
    pred.cf = 1'b0;
    if (rst_v) begin
      m_q   = '0;
      m_cnt = '0;
    end else if (en_v) begin
      for (int m = 0; m < 4; m++) begin
        for (int i = 0; i < W; i++) begin
          nb = ref_bit(m, m_q[m][i], s_v[i], r_v[i]);
          pred.ch[m][i] = nb ^ m_q[m][i];
          m_q[m][i] = nb;
        end
      end
      pred.cf = |(s_v & r_v);
      if (pred.cf && m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
    end
    pred.q   = m_q;
    pred.cnt = m_cnt;
    exp_q.push_back(pred);
    @(posedge clk);
    #1;
    want = exp_q.pop_front();
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("q_m%0d", m), {24'd0, q_mon[m]}, {24'd0, want.q[m]});
      chk($sformatf("qn_m%0d", m), {24'd0, qn_mon[m]}, {24'd0, ~want.q[m]});
      chk($sformatf("q_and_qn_m%0d", m), {24'd0, q_mon[m] & qn_mon[m]}, 32'd0);
      chk($sformatf("changed_m%0d", m), {24'd0, ch_mon[m]}, {24'd0, want.ch[m]});
      chk($sformatf("conflict_m%0d", m), {31'd0, cf_mon[m]}, {31'd0, want.cf});
`ifdef SR_CONFLICT_CNT_EN
      chk($sformatf("cnt_m%0d", m), {28'd0, cnt_mon[m]}, {28'd0, want.cnt});
`endif
    end
    n_txn++;
    $display("txn %0d rst=%0b en=%0b s=%h r=%h q=%h/%h/%h/%h chg0=%h cf=%0b", n_txn, rst_v, en_v, s_v, r_v,
             q_mon[0], q_mon[1], q_mon[2], q_mon[3], ch_mon[0], cf_mon[0]);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; s = '0; r = '0;
    m_q = '0; m_cnt = '0;

    // Reset overrides en/s/r
    step(1'b1, 1'b1, 8'hFF, 8'h00);
    step(1'b1, 1'b0, 8'h00, 8'h00);

    // Basic set on low nibble
    step(1'b0, 1'b1, 8'h0F, 8'h00);
    chk("d031_q", {24'd0, q_mon[0]}, 32'h0F);
    chk("d031_qn", {24'd0, qn_mon[0]}, 32'hF0);
    chk("d031_changed", {24'd0, ch_mon[0]}, 32'h0F);
    step(1'b0, 1'b1, 8'h00, 8'h00);
    chk("d031_changed_clr", {24'd0, ch_mon[0]}, 32'h00);

    // Mode sweep from q=A5
    step(1'b0, 1'b1, 8'hA5, 8'h5A);
    step(1'b0, 1'b1, 8'hFF, 8'hFF);
    chk("d032_m0_q", {24'd0, q_mon[0]}, 32'hA5);
    chk("d032_m0_changed", {24'd0, ch_mon[0]}, 32'h00);
    chk("d032_m1_q", {24'd0, q_mon[1]}, 32'hFF);
    chk("d032_m2_q", {24'd0, q_mon[2]}, 32'h00);
    chk("d032_m3_q", {24'd0, q_mon[3]}, 32'h5A);
    chk("d032_conflict", {31'd0, cf_mon[0]}, 32'd1);
    step(1'b0, 1'b1, 8'h00, 8'h00);
    chk("d032_conflict_clr", {31'd0, cf_mon[3]}, 32'd0);

    // Disabled edges freeze state
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 8'hFF, 8'h00);
    chk("d033_q_hold", {24'd0, q_mon[1]}, 32'hFF);

    // Counter saturation
    step(1'b1, 1'b0, 8'h00, 8'h00);
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, 1'b1, 8'h01, 8'h01);
`ifdef SR_CONFLICT_CNT_EN
      if (k == 15 || k == 20) chk($sformatf("d034_cnt_e%0d", k), {28'd0, cnt_mon[0]}, 32'd15);
`endif
    end
    step(1'b1, 1'b1, 8'h01, 8'h01);
`ifdef SR_CONFLICT_CNT_EN
    chk("d034_cnt_rst", {28'd0, cnt_mon[0]}, 32'd0);
`endif

    // Reset during MODE 3 toggling
    step(1'b1, 1'b0, 8'h00, 8'h00);
    step(1'b0, 1'b1, 8'h01, 8'h01);
    chk("d035_m3_e1", {31'd0, q_mon[3][0]}, 32'd1);
    step(1'b0, 1'b1, 8'h01, 8'h01);
    chk("d035_m3_e2", {31'd0, q_mon[3][0]}, 32'd0);
    step(1'b1, 1'b1, 8'h01, 8'h01);
    chk("d035_m3_rst_q", {24'd0, q_mon[3]}, 32'd0);
    chk("d035_m3_rst_chg", {24'd0, ch_mon[3]}, 32'd0);
    chk("d035_m3_rst_cf", {31'd0, cf_mon[3]}, 32'd0);

    // Random traffic with occasional resets
    for (int k = 0; k < 1000; k++) begin
      logic [W-1:0] rs;
      logic [W-1:0] rr;
      rs = W'($urandom);
      rr = W'($urandom);
      if ($urandom_range(0, 3) == 0) rr = rr & ~rs;
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), rs, rr);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/sr_register_bank.md
SR_REGISTER_BANK -- requirements
Module: sr_register_bank

Interface
REQ-001 Parameter WIDTH, default 8, number of independent SR channels (1..64).
REQ-002 Parameter MODE, default 0, S=R=1 resolution: 0 hold, 1 set-dominant, 2 reset-dominant, 3 toggle (JK); values >3 behave as 0.
REQ-003 Parameter INIT, default {WIDTH{1'b0}}, reset value of q.
REQ-004 Parameter CNT_W, default 8, width of conflict_cnt.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 en  input  1  clock enable; 0 freezes all state.
REQ-008 s  input  WIDTH  per-channel set request.
REQ-009 r  input  WIDTH  per-channel reset request.
REQ-010 q  output  WIDTH  registered channel state.
REQ-011 qn  output  WIDTH  complement of q.
REQ-012 changed  output  WIDTH  registered per-channel one-cycle pulse, q bit changed on last update.
REQ-013 conflict  output  1  registered pulse, at least one channel had s=r=1 on last enabled edge.
REQ-014 conflict_cnt  output  CNT_W  saturating count of enabled edges with any conflict (present only with macro, REQ-030).

Function
REQ-015 On rising edge with rst=0, en=1, each channel i SHALL update independently: s=0,r=0 hold; s=1,r=0 q=1; s=0,r=1 q=0; s=1,r=1 per MODE.
REQ-016 MODE 0: s=r=1 holds q; MODE 1: sets q=1; MODE 2: clears q=0; MODE 3: q inverts.
REQ-017 qn SHALL equal ~q at all times, derived combinationally from the q register; q[i]==qn[i] never observable.
REQ-018 Latency: q reflects s/r sampled at edge N immediately after edge N (one cycle).
REQ-019 changed[i] SHALL be 1 for exactly the cycle after an edge where q[i] took a different value, else 0.
REQ-020 conflict SHALL be 1 for the cycle after an enabled edge where |(s&r)=1, else 0; asserted in all MODEs including MODE 0.
REQ-021 en=0: q holds, changed=0, conflict=0, conflict_cnt holds, regardless of s/r.
REQ-022 conflict_cnt SHALL increment by exactly 1 per enabled edge with any conflict, independent of how many channels conflict.
REQ-023 conflict_cnt SHALL saturate at 2^CNT_W-1 and hold there until reset; no wrap.
REQ-024 MODE 3 with s=r=1 held across consecutive enabled edges SHALL toggle q every edge and pulse changed every cycle.
REQ-025 Channels SHALL not interact; a conflict on one channel SHALL not affect any other channel's q.

Reset
REQ-026 rst=1 at rising edge SHALL set q=INIT, changed=0, conflict=0, conflict_cnt=0, overriding en, s, r.
REQ-027 Reset asserted mid-operation (including during MODE 3 toggling or at counter saturation) SHALL take effect on that edge with no residual pulse on changed or conflict the following cycle.
REQ-028 Loading INIT on reset SHALL not assert changed.
REQ-029 First enabled edge with rst=0 after reset SHALL apply REQ-015 normally.

Configuration
REQ-030 Macro SR_CONFLICT_CNT_EN: defined -> conflict_cnt counter and port present per REQ-022/023; undefined -> port conflict_cnt absent, no counter logic; all other behaviour identical.

Verification
REQ-031 WIDTH=8, MODE=0, INIT=0: reset, then s=8'h0F,r=0,en=1 one edge -> q=8'h0F, qn=8'hF0, changed=8'h0F next cycle, then changed=0.
REQ-032 MODE=1/2/3 sweep: q=8'hA5, s=r=8'hFF one edge -> q=8'hFF / 8'h00 / 8'h5A, conflict=1 one cycle; MODE 0 -> q=8'hA5, changed=0, conflict=1.
REQ-033 en=0, s=8'hFF, r=0 for 5 edges -> q, conflict_cnt unchanged, changed=0, conflict=0.
REQ-034 SR_CONFLICT_CNT_EN, CNT_W=4: 20 consecutive enabled edges with s[0]=r[0]=1 -> conflict_cnt reaches 15 at edge 15, holds 15 through edge 20; rst -> 0.
REQ-035 MODE=3, q=0, s=r=8'h01 held, rst asserted on 3rd edge -> q[0] sequence 1,0 then INIT=0, changed=0 and conflict=0 the cycle after reset.
REQ-036 Random s/r/en for 1000 cycles against per-channel reference model -> q, qn, changed, conflict, conflict_cnt match every cycle; q&qn always 0.
